// File: rtl/pattern_fetch_pkg.sv
// Shared types and default widths for the pattern fetch controller.
package pattern_fetch_pkg;
  localparam int PF_ADDR_W = 20;
  localparam int PF_CNT_W  = 8;

  typedef enum logic [1:0] {IDLE, REQ, LOAD, HOLD} pf_state_t;
endpackage

// File: rtl/pattern_fetch_ctrl_pat_run_cnt.sv
// Pixel run down-counter with synchronous reload and a registered count==1 flag.
// A reload value of 0 runs for the full 2^CNT_W pixels.
module pat_run_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_last
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  logic [CNT_W-1:0] r_count;
  logic             r_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_count <= i_load_val;
      r_last  <= (i_load_val == ONE);
    end else if (i_dec) begin
      r_count <= r_count - ONE;
      r_last  <= (r_count == TWO);
    end
  end

  assign o_last = r_last;
endmodule

// File: rtl/pattern_fetch_ctrl.sv
// Pattern byte fetch sequencer: request/ack memory reads, one-cycle LDPATL strobe, pixel-run refetch.
// Optional PATFIX input (single fetch, no refetch) enabled by PATFETCH_FIXED_PATTERN_EN.
module pattern_fetch_ctrl
  import pattern_fetch_pkg::*;
#(
  parameter int ADDR_W = PF_ADDR_W,
  parameter int CNT_W  = PF_CNT_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              STOP,
  input  logic [ADDR_W-1:0] PATADDR,
  input  logic [CNT_W-1:0]  PATLEN,
  input  logic              PIXSTEP,
  output logic              MREQ,
  output logic [ADDR_W-1:0] MADDR,
  input  logic              MACK,
  output logic              LDPATL,
  output logic              PATVALID,
  output logic              BUSY
`ifdef PATFETCH_FIXED_PATTERN_EN
  ,
  input  logic              PATFIX
`endif
);
  pf_state_t         r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_len;
  logic              r_mreq, r_ldpatl, r_patvalid, r_busy;
  logic              w_start, w_refetch, w_dec, w_last, w_fix;

`ifdef PATFETCH_FIXED_PATTERN_EN
  logic r_fix;
  always_ff @(posedge CLK) begin
    if (RESET)        r_fix <= 1'b0;
    else if (w_start) r_fix <= PATFIX;
  end
  assign w_fix = r_fix;
`else
  assign w_fix = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // STOP outranks MACK, PIXSTEP and START in every non-idle state.
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_refetch = 1'b0;
    w_dec     = 1'b0;
    case (r_state)
      IDLE: begin
        if (START && !STOP) begin
          w_next  = REQ;
          w_start = 1'b1;
        end
      end
      REQ: begin
        if (STOP)      w_next = IDLE;
        else if (MACK) w_next = LOAD;
      end
      LOAD: begin
        if (STOP) w_next = IDLE;
        else      w_next = HOLD;
      end
      HOLD: begin
        if (STOP) begin
          w_next = IDLE;
        end else if (PIXSTEP && !w_fix) begin
          if (w_last) begin
            w_next    = REQ;
            w_refetch = 1'b1;
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_mreq     <= 1'b0;
      r_ldpatl   <= 1'b1;
      r_patvalid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr <= PATADDR;
        r_len  <= PATLEN;
      end else if (w_refetch) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
      r_mreq     <= (w_next == REQ);
      r_ldpatl   <= (w_next != LOAD);
      r_patvalid <= (w_next == HOLD);
      r_busy     <= (w_next != IDLE);
    end
  end

  pat_run_cnt #(.CNT_W(CNT_W)) u_run_cnt (
    .i_clk      (CLK),
    .i_rst      (RESET),
    .i_load     (w_start || w_refetch),
    .i_load_val (w_start ? PATLEN : r_len),
    .i_dec      (w_dec),
    .o_last     (w_last)
  );

  assign MREQ     = r_mreq;
  assign MADDR    = r_addr;
  assign LDPATL   = r_ldpatl;
  assign PATVALID = r_patvalid;
  assign BUSY     = r_busy;
endmodule

// File: doc/pattern_fetch_ctrl.md
Name: pattern_fetch_ctrl

Overview:
- Sequencer for the blitter's 8-bit pattern data latch. The latch is transparent while LDPATL is low and is loaded from the internal data bus ID[7:0].
- Fetches pattern bytes from memory over a request/acknowledge handshake and strobes LDPATL for exactly one cycle per fetch.
- Counts pixels consumed from the current pattern byte and re-fetches the next sequential byte when the run is exhausted.
- Sits between the blitter sequencer (START/STOP/PIXSTEP) and the memory arbiter (MREQ/MACK).

Parameters:
- ADDR_W, 20: memory address width.
- CNT_W, 8: pixel run counter width.

Ports:
- CLK  in  1  system clock; the single clock for the block.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; begin a pattern run.
- STOP  in  1  abort; return to idle.
- PATADDR  in  ADDR_W  start address of the pattern bytes, sampled on START.
- PATLEN  in  CNT_W  pixels per pattern byte, sampled on START; 0 means 2^CNT_W.
- PIXSTEP  in  1  one pixel consumed from the current pattern byte.
- MREQ  out  1  memory read request.
- MADDR  out  ADDR_W  memory read address.
- MACK  in  1  memory acknowledge; read data appears on ID[7:0] in the following cycle.
- LDPATL  out  1  active-low load strobe to the pattern data latch.
- PATVALID  out  1  pattern latch holds valid data for the current run.
- BUSY  out  1  controller not idle.

Behaviour:
- All outputs are registered.
- Reset (RESET=1 at a CLK edge):
  - state=IDLE
  - MREQ=0, MADDR=0
  - LDPATL=1
  - PATVALID=0, BUSY=0
  - run counter=0, address register=0
  - RESET overrides every other input.
- States: IDLE, REQ, LOAD, HOLD.
- IDLE:
  - START=1 → capture PATADDR into the address register and PATLEN into the reload register, load the counter, go to REQ.
  - BUSY=1 from the next cycle.
- REQ:
  - MREQ=1, MADDR=address register.
  - MACK=1 → next state LOAD, MREQ=0 next cycle.
  - MREQ stays high for however many cycles MACK is low; no timeout.
- LOAD:
  - LDPATL=0 for exactly this one cycle (the cycle after MACK), while ID carries the data.
  - Next state HOLD, with LDPATL=1 and PATVALID=1.
- HOLD:
  - PATVALID=1.
  - Each PIXSTEP decrements the counter.
  - PIXSTEP with counter==1 → address+1 (mod 2^ADDR_W, so 0xFFFFF wraps to 0x00000), counter reloaded, PATVALID=0 next cycle, go to REQ.
- PIXSTEP outside HOLD is ignored; upstream gates PIXSTEP with PATVALID.
- START while BUSY=1 is ignored.
- STOP=1 in any non-idle state:
  - Next state IDLE; MREQ=0, LDPATL=1, PATVALID=0, BUSY=0.
  - STOP has priority over MACK, PIXSTEP and START in the same cycle, so STOP together with MACK produces no LDPATL pulse.
  - The latch keeps its last contents.
- START and STOP together in IDLE: remain in IDLE.
- Latency:
  - START → MREQ: 1 cycle.
  - MACK → LDPATL low: 1 cycle.
  - LDPATL low → PATVALID: 1 cycle.
  - Minimum START→PATVALID: 3 cycles plus the MACK wait.

Optional Feature:
- Macro PATFETCH_FIXED_PATTERN_EN.
- Defined:
  - Adds input PATFIX (1 bit), sampled on START.
  - If PATFIX=1, a single fetch is made and HOLD never re-fetches; PIXSTEP is ignored and PATVALID stays high until STOP or RESET.
- Undefined: no PATFIX port; behaviour exactly as above.

Decomposition:
- Package pattern_fetch_pkg:
  - State enum pf_state_t {IDLE, REQ, LOAD, HOLD}.
  - Constants PF_ADDR_W=20, PF_CNT_W=8.
- One natural sub-module, pat_run_cnt: CNT_W down-counter with synchronous reload, decrement enable and a registered last flag (count==1).

Test Plan:
- Reset mid-REQ with MREQ=1 → next cycle MREQ=0, LDPATL=1, PATVALID=0, BUSY=0, MADDR=0.
- START with PATADDR=0x12340, PATLEN=2, MACK after 3 wait cycles → MREQ high 4 cycles at MADDR=0x12340; LDPATL low one cycle with ID=0xA5 captured; PATVALID=1.
- In HOLD, 2 PIXSTEPs → second triggers MREQ at MADDR=0x12341; PATVALID=0 until the next LOAD completes.
- PATADDR=0xFFFFF, PATLEN=1, one PIXSTEP → refetch at MADDR=0x00000.
- STOP asserted in the same cycle as MACK → no LDPATL pulse, IDLE next cycle; START during BUSY → ignored, MADDR unchanged.
- PATLEN=0 → re-fetch only after 256 PIXSTEPs; with PATFETCH_FIXED_PATTERN_EN and PATFIX=1 → single fetch, PATVALID held through 300 PIXSTEPs.
